// File: rtl/intseq_pkg.sv
// ----------------------------------------------------------------------------
// intseq_pkg
// Shared definitions for the interrupt sequencer: FSM state encoding and the
// default sizing / vector-base values used by interrupt_sequencer.
// No ports (package).
// ----------------------------------------------------------------------------
package intseq_pkg;

    localparam int         INTSEQ_NUM_IRQ     = 4;
    localparam int         INTSEQ_CODE_W      = $clog2(INTSEQ_NUM_IRQ);
    localparam int         INTSEQ_SAVE_CYCLES = 2;
    localparam logic [7:0] INTSEQ_VEC_BASE    = 8'h10;

    typedef enum logic [1:0] {
        IDLE,
        SAVE,
        JUMP,
        RESTORE
    } intseq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// ----------------------------------------------------------------------------
// irq_prio_enc
// Combinational highest-set-bit encoder. The highest index among the set
// request bits wins.
// Ports:
//   req   in   WIDTH    request vector
//   valid out  1        at least one request bit is set
//   code  out  CODE_W   index of the highest set bit (0 when none set)
// ----------------------------------------------------------------------------
module irq_prio_enc #(
    parameter int WIDTH  = 4,
    parameter int CODE_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]  req,
    output logic              valid,
    output logic [CODE_W-1:0] code
);

    // Scan upward so that a later (higher) set bit overrides a lower one.
    always_comb begin
        valid = |req;
        code  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (req[i]) begin
                code = CODE_W'(i);
            end
        end
    end

endmodule

// File: rtl/interrupt_sequencer.sv
// ----------------------------------------------------------------------------
// interrupt_sequencer
// Clocked interrupt front end for the CPU. Detects rising edges on the request
// lines, keeps them pending, applies per-line masking and strictly nested
// priority against the in-service register, and sequences interrupt entry
// (save, jump to vector) and IRET (restore).
// Ports:
//   in_CLK      in   1        system clock, rising edge
//   in_RST      in   1        asynchronous reset, active-low
//   in_IR       in   NUM_IRQ  raw request lines (0->1 edge raises pending)
//   in_INM      in   NUM_IRQ  per-line mask, 1 = masked
//   in_IE_SET   in   1        STI strobe
//   in_IE_CLR   in   1        CLI strobe (beats STI)
//   in_ACK      in   1        CPU accepts out_break at instruction boundary
//   in_IRET     in   1        CPU executes IRET
//   out_break   out  1        interrupt request to CPU
//   out_code    out  CODE_W   requested (IDLE) or latched code
//   out_save    out  1        push PC/flags, held SAVE_CYCLES cycles
//   out_jump    out  1        one-cycle strobe, load PC from out_vector
//   out_vector  out  8        VEC_BASE + code*4 while out_jump, else 0
//   out_restore out  1        pop PC/flags, held SAVE_CYCLES cycles
//   out_IE      out  1        global interrupt enable
//   out_ISR     out  NUM_IRQ  in-service bits
//   out_err     out  1        one-cycle pulse after IRET with nothing in service
// ----------------------------------------------------------------------------
module interrupt_sequencer
    import intseq_pkg::*;
#(
    parameter int         NUM_IRQ     = INTSEQ_NUM_IRQ,
    parameter int         SAVE_CYCLES = INTSEQ_SAVE_CYCLES,
    parameter logic [7:0] VEC_BASE    = INTSEQ_VEC_BASE
) (
    input  logic                       in_CLK,
    input  logic                       in_RST,
    input  logic [NUM_IRQ-1:0]         in_IR,
    input  logic [NUM_IRQ-1:0]         in_INM,
    input  logic                       in_IE_SET,
    input  logic                       in_IE_CLR,
    input  logic                       in_ACK,
    input  logic                       in_IRET,
    output logic                       out_break,
    output logic [$clog2(NUM_IRQ)-1:0] out_code,
    output logic                       out_save,
    output logic                       out_jump,
    output logic [7:0]                 out_vector,
    output logic                       out_restore,
    output logic                       out_IE,
    output logic [NUM_IRQ-1:0]         out_ISR,
    output logic                       out_err
);

    localparam int         CODE_W   = $clog2(NUM_IRQ);
    localparam logic [2:0] SAVE_LEN = 3'(SAVE_CYCLES);

    intseq_state_e state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;

    logic [NUM_IRQ-1:0] ir_q, edge_q, pend_q, inm_q, isr_q;
    logic [NUM_IRQ-1:0] eff, pend_clr;
    logic [CODE_W-1:0]  code_q, eff_code, isr_code;
    logic               eff_valid, isr_valid;
    logic               ie_q, err_q;
    logic               take_ack, take_iret, iret_err, restore_done;

    // Mask is registered so out_break depends on flops only.
    // A line is eligible only when nothing at its own level or above is in service.
    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_eff
        assign eff[i] = pend_q[i] & ~inm_q[i] & ~(|isr_q[NUM_IRQ-1:i]);
    end

    irq_prio_enc #(.WIDTH(NUM_IRQ), .CODE_W(CODE_W)) u_eff_enc (
        .req   (eff),
        .valid (eff_valid),
        .code  (eff_code)
    );

    irq_prio_enc #(.WIDTH(NUM_IRQ), .CODE_W(CODE_W)) u_isr_enc (
        .req   (isr_q),
        .valid (isr_valid),
        .code  (isr_code)
    );

    assign out_break   = ie_q & eff_valid & (state_q == IDLE);
    assign out_code    = (state_q == IDLE) ? eff_code : code_q;
    assign out_save    = (state_q == SAVE);
    assign out_jump    = (state_q == JUMP);
    assign out_restore = (state_q == RESTORE);
    assign out_vector  = out_jump ? 8'(VEC_BASE + (8'(code_q) << 2)) : 8'h00;
    assign out_IE      = ie_q;
    assign out_ISR     = isr_q;
    assign out_err     = err_q;

    // Next-state logic. ACK takes priority over IRET in IDLE; both are ignored
    // elsewhere. The counter counts cycles spent in the current state and is
    // reloaded to 1 whenever a new state is entered.
    always_comb begin
        state_d      = state_q;
        cnt_d        = (cnt_q == 3'd7) ? cnt_q : cnt_q + 3'd1;
        take_ack     = 1'b0;
        take_iret    = 1'b0;
        iret_err     = 1'b0;
        restore_done = 1'b0;
        pend_clr     = '0;
        case (state_q)
            IDLE: begin
                if (in_ACK && out_break) begin
                    take_ack           = 1'b1;
                    pend_clr[eff_code] = 1'b1;
                    state_d            = SAVE;
                    cnt_d              = 3'd1;
                end else if (in_IRET && isr_valid) begin
                    take_iret = 1'b1;
                    state_d   = RESTORE;
                    cnt_d     = 3'd1;
                end else if (in_IRET) begin
                    iret_err = 1'b1;
                end
            end
            SAVE: begin
                if (cnt_q >= SAVE_LEN) begin
                    state_d = JUMP;
                    cnt_d   = 3'd1;
                end
            end
            JUMP: begin
                state_d = IDLE;
                cnt_d   = 3'd1;
            end
            RESTORE: begin
                if (cnt_q >= SAVE_LEN) begin
                    restore_done = 1'b1;
                    state_d      = IDLE;
                    cnt_d        = 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 3'd1;
            end
        endcase
    end

    // State register.
    always_ff @(posedge in_CLK or negedge in_RST) begin
        if (!in_RST) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Edge detection, pending, in-service and enable bookkeeping.
    // A new edge on the accepted line in the entry cycle keeps it pending.
    // SAVE entry and RESTORE exit override the STI/CLI strobes.
    always_ff @(posedge in_CLK or negedge in_RST) begin
        if (!in_RST) begin
            ir_q   <= '0;
            edge_q <= '0;
            inm_q  <= '0;
            pend_q <= '0;
            isr_q  <= '0;
            code_q <= '0;
            ie_q   <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            ir_q   <= in_IR;
            edge_q <= in_IR & ~ir_q;
            inm_q  <= in_INM;
            pend_q <= (pend_q & ~pend_clr) | edge_q;
            err_q  <= iret_err;

            if (take_ack) begin
                code_q          <= eff_code;
                isr_q[eff_code] <= 1'b1;
            end else if (take_iret) begin
                code_q          <= isr_code;
                isr_q[isr_code] <= 1'b0;
            end

            if (take_ack) begin
                ie_q <= 1'b0;
            end else if (restore_done) begin
                ie_q <= 1'b1;
            end else if (in_IE_CLR) begin
                ie_q <= 1'b0;
            end else if (in_IE_SET) begin
                ie_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// ----------------------------------------------------------------------------
// tb_interrupt_sequencer
// Directed bench for interrupt_sequencer: reset state, entry sequence, priority,
// nesting, masking, IRET error, STI/CLI precedence and async reset mid-SAVE.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// ----------------------------------------------------------------------------
module tb_interrupt_sequencer;

    logic       in_CLK;
    logic       in_RST;
    logic [3:0] in_IR;
    logic [3:0] in_INM;
    logic       in_IE_SET;
    logic       in_IE_CLR;
    logic       in_ACK;
    logic       in_IRET;
    logic       out_break;
    logic [1:0] out_code;
    logic       out_save;
    logic       out_jump;
    logic [7:0] out_vector;
    logic       out_restore;
    logic       out_IE;
    logic [3:0] out_ISR;
    logic       out_err;

    int checks   = 0;
    int failures = 0;

    interrupt_sequencer dut (
        .in_CLK      (in_CLK),
        .in_RST      (in_RST),
        .in_IR       (in_IR),
        .in_INM      (in_INM),
        .in_IE_SET   (in_IE_SET),
        .in_IE_CLR   (in_IE_CLR),
        .in_ACK      (in_ACK),
        .in_IRET     (in_IRET),
        .out_break   (out_break),
        .out_code    (out_code),
        .out_save    (out_save),
        .out_jump    (out_jump),
        .out_vector  (out_vector),
        .out_restore (out_restore),
        .out_IE      (out_IE),
        .out_ISR     (out_ISR),
        .out_err     (out_err)
    );

    initial in_CLK = 1'b0;
    always #5 in_CLK = ~in_CLK;

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive the strobes for exactly one rising edge, then drop them.
    task automatic applyStimulus(input logic ie_set, input logic ie_clr,
                                 input logic ack, input logic iret);
        in_IE_SET = ie_set;
        in_IE_CLR = ie_clr;
        in_ACK    = ack;
        in_IRET   = iret;
        @(posedge in_CLK);
        #1;
        in_IE_SET = 1'b0;
        in_IE_CLR = 1'b0;
        in_ACK    = 1'b0;
        in_IRET   = 1'b0;
    endtask

    task automatic doReset();
        in_IR     = '0;
        in_INM    = '0;
        in_IE_SET = 1'b0;
        in_IE_CLR = 1'b0;
        in_ACK    = 1'b0;
        in_IRET   = 1'b0;
        in_RST    = 1'b0;
        repeat (2) @(posedge in_CLK);
        #1;
        in_RST = 1'b1;
    endtask

    // Guard against a hung run.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        in_RST    = 1'b0;
        in_IR     = '0;
        in_INM    = '0;
        in_IE_SET = 1'b0;
        in_IE_CLR = 1'b0;
        in_ACK    = 1'b0;
        in_IRET   = 1'b0;
        #2;
        checkOutput("rst_break",   out_break,   0);
        checkOutput("rst_code",    out_code,    0);
        checkOutput("rst_save",    out_save,    0);
        checkOutput("rst_jump",    out_jump,    0);
        checkOutput("rst_vector",  out_vector,  0);
        checkOutput("rst_restore", out_restore, 0);
        checkOutput("rst_ie",      out_IE,      0);
        checkOutput("rst_isr",     out_ISR,     0);
        checkOutput("rst_err",     out_err,     0);
        @(posedge in_CLK);
        #1;
        in_RST = 1'b1;

        // Basic entry on line 1, then IRET back.
        $display("[TB] single request on line 1");
        applyStimulus(1, 0, 0, 0);
        checkOutput("t1_ie_set", out_IE, 1);
        in_IR = 4'b0010;
        applyStimulus(0, 0, 0, 0);
        checkOutput("t1_break_early", out_break, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("t1_break", out_break, 1);
        checkOutput("t1_code",  out_code,  1);
        applyStimulus(0, 0, 1, 0);
        checkOutput("t1_save1",     out_save,  1);
        checkOutput("t1_isr",       out_ISR,   4'b0010);
        checkOutput("t1_ie_cleared", out_IE,   0);
        checkOutput("t1_break_off", out_break, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("t1_save2", out_save, 1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("t1_save_end", out_save,   0);
        checkOutput("t1_jump",     out_jump,   1);
        checkOutput("t1_vector",   out_vector, 8'h14);
        applyStimulus(0, 0, 0, 0);
        checkOutput("t1_jump_end", out_jump, 0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("t1_restore1", out_restore, 1);
        checkOutput("t1_isr_clr",  out_ISR,     0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("t1_restore2", out_restore, 1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("t1_restore_end", out_restore, 0);
        checkOutput("t1_ie_back",     out_IE,      1);

        // Lines 0 and 3 together: 3 first, then 0 after IRET.
        $display("[TB] priority between lines 0 and 3");
        in_IR = 4'b1011;
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("t2_break", out_break, 1);
        checkOutput("t2_code3", out_code,  3);
        applyStimulus(0, 0, 1, 0);
        checkOutput("t2_isr3", out_ISR, 4'b1000);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("t2_vector3", out_vector, 8'h1C);
        applyStimulus(0, 0, 0, 0);
        checkOutput("t2_break_ie0", out_break, 0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("t2_restore1", out_restore, 1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("t2_restore2", out_restore, 1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("t2_ie_back", out_IE,    1);
        checkOutput("t2_break0",  out_break, 1);
        checkOutput("t2_code0",   out_code,  0);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("t2_vector0", out_vector, 8'h10);
        checkOutput("t2_isr0",    out_ISR,    4'b0001);

        // Nesting against ISR bit 1.
        $display("[TB] nested service");
        doReset();
        applyStimulus(1, 0, 0, 0);
        in_IR = 4'b0010;
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("t3_isr1", out_ISR, 4'b0010);
        checkOutput("t3_ie",   out_IE,  1);
        in_IR = 4'b0011;
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("t3_low_blocked", out_break, 0);
        in_IR = 4'b0111;
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("t3_break2", out_break, 1);
        checkOutput("t3_code2",  out_code,  2);
        applyStimulus(0, 0, 1, 0);
        checkOutput("t3_isr_nested", out_ISR, 4'b0110);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("t3_vector2", out_vector, 8'h18);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("t3_iret_isr",  out_ISR,     4'b0010);
        checkOutput("t3_iret_code", out_code,    2);
        checkOutput("t3_restore",   out_restore, 1);

        // Masking of line 3.
        $display("[TB] masking");
        doReset();
        in_INM = 4'b1000;
        applyStimulus(1, 0, 0, 0);
        in_IR = 4'b1000;
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("t4_masked", out_break, 0);
        in_INM = 4'b0000;
        checkOutput("t4_mask_lag", out_break, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("t4_unmasked", out_break, 1);
        checkOutput("t4_code3",    out_code,  3);

        // IRET error, stray ACK, STI/CLI precedence.
        $display("[TB] iret error and enable strobes");
        doReset();
        applyStimulus(0, 0, 1, 0);
        checkOutput("t5_ack_ignored", out_save, 0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("t5_err",        out_err,     1);
        checkOutput("t5_no_restore", out_restore, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("t5_err_pulse", out_err, 0);
        applyStimulus(1, 1, 0, 0);
        checkOutput("t5_clr_wins_low", out_IE, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("t5_sti", out_IE, 1);
        applyStimulus(1, 1, 0, 0);
        checkOutput("t5_clr_wins_high", out_IE, 0);

        // Async reset in the middle of SAVE.
        $display("[TB] reset during save");
        doReset();
        applyStimulus(1, 0, 0, 0);
        in_IR = 4'b0011;
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("t6_code1", out_code, 1);
        applyStimulus(0, 0, 1, 0);
        checkOutput("t6_save", out_save, 1);
        #2;
        in_RST = 1'b0;
        in_IR  = 4'b0000;
        #1;
        checkOutput("t6_save_abort", out_save,  0);
        checkOutput("t6_isr_abort",  out_ISR,   0);
        checkOutput("t6_code_abort", out_code,  0);
        checkOutput("t6_ie_abort",   out_IE,    0);
        checkOutput("t6_jump_abort", out_jump,  0);
        @(posedge in_CLK);
        #1;
        in_RST = 1'b1;
        applyStimulus(1, 0, 0, 0);
        checkOutput("t6_ie_after",   out_IE,    1);
        checkOutput("t6_pend_clear", out_break, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
